pkt_hdr_reader: RTL
===================

Name: pkt_hdr_reader

Overview:
- Read side of the ping-pong packet-header RAM (PKT_HDR_RAM) that the header-update block fills.
- Reads the stable bank word by word and emits each stored header as one 134-bit packet toward the FPGA OS output path.
- Paces packets with a programmable inter-packet gap and downstream back-pressure.
- Sits in PGM; reports sent-packet count and completion to LCM.

Parameters:
- HDR_LEN, 8: 128-bit words per stored header/packet; legal 2..32.
- GAP_CYCLES, 16: idle cycles between the last word of one packet and the first RAM read of the next; legal 0..255.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- in_phr_addr_shift  input  1  bank pointer from header-update block; readable bank = {in_phr_addr_shift,5'd0}
- in_phr_update_finish  input  1  level; at least one header set has been written
- in_phr_test_start  input  1  level; enables generation
- in_phr_pkt_total  input  16  packets to send per run; 0 = unlimited
- out_phr_ram_rd  output  1  RAM read strobe
- out_phr_ram_addr  output  6  RAM read address
- in_phr_ram_rdata  input  128  RAM data, valid exactly 1 cycle after out_phr_ram_rd
- in_phr_alf  input  1  downstream almost-full
- out_phr_data_wr  output  1  output data valid
- out_phr_data  output  134  [133:132] 01=first, 11=middle, 10=last; [131:128]=4'h0; [127:0]=RAM word
- out_phr_pkt_cnt  output  16  packets sent in current run
- out_phr_send_finish  output  1  level; run complete

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Every flop samples rst on the rising edge of clk.
- Reset values: all outputs 0; state=IDLE_S; word counter, gap counter and bank latch cleared.

States:
- IDLE_S:
  - Clear out_phr_pkt_cnt and out_phr_send_finish when in_phr_test_start=0.
  - Go to START_S when in_phr_test_start=1, in_phr_update_finish=1 and out_phr_send_finish=0.
- START_S:
  - Wait while in_phr_alf=1.
  - Otherwise latch bank<=in_phr_addr_shift, word counter<=0, go to READ_S.
- READ_S:
  - Each cycle: out_phr_ram_rd=1, out_phr_ram_addr={bank,word[4:0]}, word increments.
  - After issuing word HDR_LEN-1, go to DRAIN_S.
  - Reads are never stalled mid-packet; in_phr_alf is checked only in START_S.
- DRAIN_S:
  - One cycle for the final rdata.
  - Then increment out_phr_pkt_cnt (wrap at 16'hFFFF->0 when unlimited).
  - If in_phr_pkt_total!=0 and new count==in_phr_pkt_total: set out_phr_send_finish=1, go to IDLE_S.
  - Else if in_phr_test_start=0: go to IDLE_S.
  - Else go to GAP_S with gap counter=0.
- GAP_S:
  - Count GAP_CYCLES cycles, then go to START_S.
  - GAP_CYCLES=0 skips GAP_S entirely.

Output pipeline:
- Read strobe delayed by 1 cycle = data-valid; first/last flags pipelined alongside.
- out_phr_data registered from in_phr_ram_rdata: out_phr_data_wr asserts 2 cycles after the matching out_phr_ram_rd.
- Exactly HDR_LEN contiguous output cycles per packet: word0 tag 01, word HDR_LEN-1 tag 10, others 11.

Boundary conditions:
- Bank consistency: the bank is latched per packet. A toggle of in_phr_addr_shift mid-packet affects only the next packet, so a packet never mixes banks.
- Test-start deassertion: deasserting in_phr_test_start mid-packet finishes the current packet, then returns to IDLE_S. Reasserting restarts the count from 0.
- Finished run: out_phr_send_finish holds until in_phr_test_start=0, which returns the block to idle.
- Write/read overlap: the writer owns bank ~in_phr_addr_shift, so no write/read overlap handling is required.
- Mid-operation reset: synchronous reset during any state aborts immediately; output valid drops the next cycle and no partial tail is emitted.

Test Plan:
- Basic packet: addr_shift=0, update_finish=1, start=1, total=1, HDR_LEN=8, RAM word i=i. Expect reads at addr 0..7 and 8 data cycles: tags 01, 11×6, 10; data 0..7; pkt_cnt=1; send_finish=1; no further reads.
- Bank select: addr_shift=1, total=2. Expect reads at 32..39 twice. The gap between packet1 last data and packet2 first data = GAP_CYCLES+3 cycles (DRAIN_S, START_S, RAM latency).
- Bank switch mid-packet: toggle addr_shift 1->0 on the 3rd read. Expect the current packet completes at 32..39 and the next packet reads 0..7.
- Back-pressure: assert alf during GAP_S and hold 20 cycles. Expect no read until alf=0 in START_S. alf asserted mid-READ_S does not interrupt the 8 contiguous words.
- Unlimited/stop: total=0, start=1 for 5 packets, drop start mid-packet 5. Expect packet 5 completes fully, pkt_cnt=5, then IDLE_S with pkt_cnt cleared next cycle and send_finish=0.
- Reset mid-packet: rst=1 at word 4 of a packet. Next cycle all outputs 0, state IDLE_S; after release with start=1, a new full packet starts from word 0.

Source files
------------

// File: rtl/pkt_hdr_reader.sv
// Reads the stable bank of the ping-pong header RAM and replays each stored header
// as one tagged multi-word packet, paced by an inter-packet gap and downstream almost-full.
module pkt_hdr_reader #(
    parameter int HDR_LEN    = 8,
    parameter int GAP_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_phr_addr_shift,
    input  logic         in_phr_update_finish,
    input  logic         in_phr_test_start,
    input  logic [15:0]  in_phr_pkt_total,
    output logic         out_phr_ram_rd,
    output logic [5:0]   out_phr_ram_addr,
    input  logic [127:0] in_phr_ram_rdata,
    input  logic         in_phr_alf,
    output logic         out_phr_data_wr,
    output logic [133:0] out_phr_data,
    output logic [15:0]  out_phr_pkt_cnt,
    output logic         out_phr_send_finish
);

    typedef enum logic [2:0] {
        IDLE_S  = 3'd0,
        START_S = 3'd1,
        READ_S  = 3'd2,
        DRAIN_S = 3'd3,
        GAP_S   = 3'd4
    } state_t;

    localparam logic [4:0] LAST_WORD = 5'(HDR_LEN - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  word;
    logic [4:0]  word_nxt;
    logic [7:0]  gap;
    logic [7:0]  gap_nxt;
    logic        bank;
    logic        bank_nxt;
    logic [15:0] pkt_cnt_nxt;
    logic        finish_nxt;

    logic        rd_q;
    logic        first_q;
    logic        last_q;
    logic [1:0]  tag;

    // Flow control: out_phr_data_wr is a push-only strobe with no ready; the sink
    // throttles by raising in_phr_alf, which is honoured only between packets.
    always_comb begin
        state_nxt      = state;
        word_nxt       = word;
        gap_nxt        = gap;
        bank_nxt       = bank;
        pkt_cnt_nxt    = out_phr_pkt_cnt;
        finish_nxt     = out_phr_send_finish;
        out_phr_ram_rd = 1'b0;
        case (state)
            IDLE_S: begin
                if (!in_phr_test_start) begin
                    pkt_cnt_nxt = '0;
                    finish_nxt  = 1'b0;
                end
                if (in_phr_test_start && in_phr_update_finish && !out_phr_send_finish)
                    state_nxt = START_S;
            end
            START_S: begin
                if (!in_phr_alf) begin
                    bank_nxt  = in_phr_addr_shift;
                    word_nxt  = '0;
                    state_nxt = READ_S;
                end
            end
            READ_S: begin
                out_phr_ram_rd = 1'b1;
                word_nxt       = word + 5'd1;
                if (word == LAST_WORD)
                    state_nxt = DRAIN_S;
            end
            DRAIN_S: begin
                pkt_cnt_nxt = out_phr_pkt_cnt + 16'd1;
                if (in_phr_pkt_total != 16'd0 && pkt_cnt_nxt == in_phr_pkt_total) begin
                    finish_nxt = 1'b1;
                    state_nxt  = IDLE_S;
                end else if (!in_phr_test_start) begin
                    state_nxt = IDLE_S;
                end else if (GAP_CYCLES == 0) begin
                    state_nxt = START_S;
                end else begin
                    gap_nxt   = '0;
                    state_nxt = GAP_S;
                end
            end
            GAP_S: begin
                if (gap == GAP_LAST)
                    state_nxt = START_S;
                else
                    gap_nxt = gap + 8'd1;
            end
            default: state_nxt = IDLE_S;
        endcase
    end

    assign out_phr_ram_addr = out_phr_ram_rd ? {bank, word} : 6'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE_S;
            word                <= '0;
            gap                 <= '0;
            bank                <= 1'b0;
            out_phr_pkt_cnt     <= '0;
            out_phr_send_finish <= 1'b0;
        end else begin
            state               <= state_nxt;
            word                <= word_nxt;
            gap                 <= gap_nxt;
            bank                <= bank_nxt;
            out_phr_pkt_cnt     <= pkt_cnt_nxt;
            out_phr_send_finish <= finish_nxt;
        end
    end

    // Position flags ride one stage behind the read so they line up with rdata.
    assign tag = first_q ? 2'b01 : (last_q ? 2'b10 : 2'b11);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q            <= 1'b0;
            first_q         <= 1'b0;
            last_q          <= 1'b0;
            out_phr_data_wr <= 1'b0;
            out_phr_data    <= '0;
        end else begin
            rd_q            <= out_phr_ram_rd;
            first_q         <= out_phr_ram_rd && (word == 5'd0);
            last_q          <= out_phr_ram_rd && (word == LAST_WORD);
            out_phr_data_wr <= rd_q;
            out_phr_data    <= rd_q ? {tag, 4'h0, in_phr_ram_rdata} : '0;
        end
    end

endmodule
